oric_tape_writer: RTL and testbench
===================================

# oric_tape_writer

Recovers bytes from the Oric core's cassette output (`K7_TAPEOUT`) and writes them into a byte-wide tape buffer RAM, so a program SAVEd on the emulated machine can later be uploaded to the HPS as a TAP image. It is the record-side counterpart of the tape playback path.

- Input: the serial square wave, gated by the cassette relay.
- Decode: measures full-cycle periods, classifies each as a 1 or 0 bit, and de-frames the bits into bytes.
- Output: sequential RAM writes, plus status flags.

## Interface
Parameters:
- `TICK_DIV`, 24: clk_sys cycles per 1 µs tick.
- `MIN_US`, 300: cycles shorter than this are glitches.
- `SPLIT_US`, 520: cycles shorter than this are bit 1; cycles at or above it are bit 0.
- `MAX_US`, 900: cycles at or above this are silence.
- `ADDR_W`, 16: buffer address width.
- `PARITY_ODD`, 1: 1 = odd parity over data + parity bit.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tape_out` in 1: asynchronous cassette output from the core.
- `relay` in 1: motor relay; recording is enabled while high.
- `rewind` in 1: synchronous clear of address and flags.
- `wr_en` out 1: one-cycle write strobe to the buffer RAM.
- `wr_addr` out ADDR_W: write address, valid while `wr_en` is high.
- `wr_data` out 8: byte to write.
- `byte_count` out ADDR_W+1: bytes stored since rewind.
- `parity_err` out 1: sticky parity error.
- `frame_err` out 1: sticky framing error.
- `full` out 1: buffer full; further bytes are dropped.
- `active` out 1: relay high and carrier present (not silence).

## Operation
- **Input conditioning:** `tape_out` passes through a 2-FF synchronizer, then a 1-FF delay for rising-edge detection.
- **Tick and period counters:** a prescaler counts 0..TICK_DIV-1 and emits a tick at wrap. A 10-bit period counter increments on each tick and saturates at 1023.
- **On each rising edge:**
  - The previous period P is classified: GLITCH if P<MIN_US, ONE if P<SPLIT_US, ZERO if P<MAX_US, else SILENCE.
  - The period counter and prescaler are then cleared.
  - The first edge after reset, rewind, relay rising or silence is classified FIRST and ignored.
- **Timeout:** if the period counter reaches MAX_US with no edge, SILENCE is declared, the FSM returns to HUNT, and `active` falls.
- **Framer FSM:**
  - HUNT: ONE or GLITCH → stay. ZERO (start bit) → DATA, with bit index 0.
  - DATA: shift LSB first. After 8 bits → PARITY.
  - PARITY: compare the received bit against the expected parity; a mismatch sets `parity_err`. The byte is written regardless. Go to STOP.
  - STOP: ONE → HUNT. ZERO → set `frame_err`, then HUNT.
  - GLITCH in DATA, PARITY or STOP → set `frame_err`, discard the partial byte, go to HUNT.
- **Write:**
  - Issued when the PARITY bit is classified and `full` is low.
  - `wr_addr` increments after each write.
  - When the write to address 2^ADDR_W-1 completes, `full` is set and the address does not wrap.
- **Relay low:** the FSM is forced to HUNT, the partial byte is discarded, and no writes occur. The address is retained, so relay toggles append to the buffer.
- **Rewind:**
  - Clears `wr_addr`, `byte_count`, `parity_err`, `frame_err`, `full` and the FSM.
  - Has priority over a simultaneous write: that write is suppressed.
- **Reset:** every output is 0, the FSM is in HUNT, and the period counter is saturated (so the next edge is FIRST). Reset asserted mid-byte aborts the byte with no write.

## Timing
- Edge detection: cycle E, which is 3 clk_sys cycles after the `tape_out` rising edge. Classification and FSM update happen in cycle E.
- Write strobe:
  - `wr_en` goes high in E+1 for exactly one cycle, with `wr_data` and `wr_addr` stable.
  - `wr_addr` and `byte_count` update in E+2.
- Flags set in E+1. `active` updates 1 cycle after the relay change or silence detection.
- Minimum edge spacing handled: 2 clk_sys cycles (classified GLITCH).
- Arithmetic:
  - Comparisons are unsigned on the 10-bit period.
  - `byte_count` is ADDR_W+1 bits so it can reach 2^ADDR_W.

## Structure
- Package `oric_tape_pkg`:
  - FSM state enum {HUNT, DATA, PARITY, STOP}.
  - Bit-class enum {FIRST, GLITCH, ONE, ZERO, SILENCE}.
  - Default µs constants.
- Sub-module `oric_tape_period_meter` contains the synchronizer, edge detector, prescaler, period counter and classifier. It outputs `bit_valid` + class.
- The top level holds the framer FSM, shift register, parity, address and flags.

## Test plan
- Byte 0x16, correct odd parity, cycles at 416/624 µs → `wr_en` once, `wr_data`=0x16, `wr_addr`=0, `byte_count`=1, no flags.
- 0x24 then 0x41 with a wrong parity bit on the second → two writes at 0 and 1; `parity_err`=1 after the second write.
- Relay dropped after 4 data bits, then a full 0x55 frame after the relay rises → only 0x55 written, at the next address.
- 100 µs pulse inside the data bits → `frame_err`=1, no write; the following clean byte is decoded correctly.
- ADDR_W=4: 17 bytes sent → 16 writes, `full`=1, the 17th is dropped. Then `rewind` → address 0, all flags 0.
- 1 ms gap mid-byte → `active`=0, FSM in HUNT, no write. `reset_n` pulse mid-byte → all outputs 0.

Source files
------------

// File: rtl/oric_tape_pkg.sv
// Shared types, default timing constants and the period classifier for the Oric
// cassette record path.
package oric_tape_pkg;

    typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} state_e;
    typedef enum logic [2:0] {FIRST, GLITCH, ONE, ZERO, SILENCE} bit_class_e;

    localparam int unsigned DEF_TICK_DIV = 24;
    localparam int unsigned DEF_MIN_US   = 300;
    localparam int unsigned DEF_SPLIT_US = 520;
    localparam int unsigned DEF_MAX_US   = 900;

    localparam int PER_W = 10;
    localparam logic [PER_W-1:0] PER_SAT = '1;

    function automatic bit_class_e classify_period(
        input logic [PER_W-1:0] period,
        input int unsigned      min_us,
        input int unsigned      split_us,
        input int unsigned      max_us
    );
        int unsigned p;
        p = 32'(period);
        if (p < min_us)   return GLITCH;
        if (p < split_us) return ONE;
        if (p < max_us)   return ZERO;
        return SILENCE;
    endfunction

endpackage

// File: rtl/oric_tape_period_meter.sv
// Synchronizes the cassette square wave, times each rising-edge-to-rising-edge
// period in microsecond ticks and classifies it as a tape bit.
module oric_tape_period_meter
    import oric_tape_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned MIN_US   = DEF_MIN_US,
    parameter int unsigned SPLIT_US = DEF_SPLIT_US,
    parameter int unsigned MAX_US   = DEF_MAX_US
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tape_out,
    input  logic       rearm,
    output logic       bit_valid,
    output bit_class_e bit_class,
    output logic       carrier_lost
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [PER_W-1:0] PER_TIMEOUT = PER_W'(MAX_US - 1);

    logic [1:0]       sync_q, sync_d;
    logic             dly_q, dly_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             first_q, first_d;
    logic             rise, tick, timeout;

    always_comb begin
        sync_d   = {sync_q[0], tape_out};
        dly_d    = sync_q[1];
        rise     = sync_q[1] & ~dly_q;
        tick     = (pre_q == PRE_LAST);
        timeout  = tick & (period_q == PER_TIMEOUT) & ~rise & ~rearm;

        pre_d    = tick ? '0 : pre_q + 1'b1;
        period_d = period_q;
        first_d  = first_q;
        if (tick && period_q != PER_SAT) period_d = period_q + 1'b1;
        if (timeout) first_d = 1'b1;
        if (rise) begin
            pre_d    = '0;
            period_d = '0;
            first_d  = 1'b0;
        end
        // Rearm parks the counter at saturation so the next edge reads as FIRST.
        if (rearm) begin
            pre_d    = '0;
            period_d = PER_SAT;
            first_d  = 1'b1;
        end

        bit_valid = (rise & ~rearm) | timeout;
        bit_class = SILENCE;
        if (rise) bit_class = first_q ? FIRST : classify_period(period_q, MIN_US, SPLIT_US, MAX_US);
        carrier_lost = (32'(period_q) >= MAX_US);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            dly_q    <= 1'b0;
            pre_q    <= '0;
            period_q <= PER_SAT;
            first_q  <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            pre_q    <= pre_d;
            period_q <= period_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: rtl/oric_tape_writer.sv
// Oric cassette record path: frames classified tape bits into bytes and writes them
// sequentially into the tape buffer RAM.
//  state  | meaning
//  HUNT   | waiting for a ZERO start bit
//  DATA   | shifting 8 data bits, LSB first
//  PARITY | checking the parity bit and issuing the buffer write
//  STOP   | expecting the ONE stop bit
module oric_tape_writer
    import oric_tape_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned SPLIT_US   = DEF_SPLIT_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int          ADDR_W     = 16,
    parameter int unsigned PARITY_ODD = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              tape_out,
    input  logic              relay,
    input  logic              rewind,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              parity_err,
    output logic              frame_err,
    output logic              full,
    output logic              active
);

    logic       bit_valid, carrier_lost;
    bit_class_e bit_class;

    oric_tape_period_meter #(
        .TICK_DIV (TICK_DIV),
        .MIN_US   (MIN_US),
        .SPLIT_US (SPLIT_US),
        .MAX_US   (MAX_US)
    ) u_meter (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .tape_out     (tape_out),
        .rearm        (rewind | ~relay),
        .bit_valid    (bit_valid),
        .bit_class    (bit_class),
        .carrier_lost (carrier_lost)
    );

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, full_q, full_d, active_q, active_d;
    logic              fire, perr_set, ferr_set, is_one, is_bit, exp_par;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fire     = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        is_one   = (bit_class == ONE);
        is_bit   = is_one | (bit_class == ZERO);
        exp_par  = (^shift_q) ^ (PARITY_ODD != 0);

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    if (bit_class == ZERO) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (is_bit) begin
                        shift_d = {is_one, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 3'd7) state_d = PARITY;
                    end else begin
                        state_d  = HUNT;
                        ferr_set = (bit_class == GLITCH);
                    end
                end
                PARITY: begin
                    if (is_bit) begin
                        perr_set = (is_one != exp_par);
                        fire     = 1'b1;
                        state_d  = STOP;
                    end else begin
                        state_d  = HUNT;
                        ferr_set = (bit_class == GLITCH);
                    end
                end
                STOP: begin
                    state_d  = HUNT;
                    ferr_set = (bit_class == ZERO) | (bit_class == GLITCH);
                end
                default: state_d = HUNT;
            endcase
        end

        if (rewind || !relay) begin
            state_d  = HUNT;
            fire     = 1'b0;
            perr_set = 1'b0;
            ferr_set = 1'b0;
        end

        wr_en_d   = fire & ~full_q;
        wr_data_d = fire ? shift_q : wr_data_q;
        addr_d    = addr_q;
        count_d   = count_q;
        full_d    = full_q;
        perr_d    = perr_q | perr_set;
        ferr_d    = ferr_q | ferr_set;
        active_d  = relay & ~carrier_lost;

        // Address advances the cycle after the strobe; the last slot sets full instead of wrapping.
        if (wr_en_q) begin
            count_d = count_q + 1'b1;
            if (addr_q == '1) full_d = 1'b1;
            else              addr_d = addr_q + 1'b1;
        end

        if (rewind) begin
            wr_en_d = 1'b0;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            full_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            full_q    <= full_d;
            active_q  <= active_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = wr_data_q;
    assign byte_count = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign full       = full_q;
    assign active     = active_q;

endmodule

// File: tb/tb_oric_tape_writer.sv
// Bench for oric_tape_writer: drives framed tape bytes with randomized cycle lengths
// and compares writes and flags against a byte-level model of the buffer.
module tb_oric_tape_writer;

    localparam int TICK_DIV = 2;
    localparam int MIN_US   = 30;
    localparam int SPLIT_US = 52;
    localparam int MAX_US   = 90;
    localparam int ADDR_W   = 4;
    localparam int LAST_ADDR = (1 << ADDR_W) - 1;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              tape_out = 1'b0;
    logic              relay = 1'b0;
    logic              rewind = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   byte_count;
    logic              parity_err, frame_err, full, active;

    always #5 clk_sys = ~clk_sys;

    oric_tape_writer #(
        .TICK_DIV   (TICK_DIV),
        .MIN_US     (MIN_US),
        .SPLIT_US   (SPLIT_US),
        .MAX_US     (MAX_US),
        .ADDR_W     (ADDR_W),
        .PARITY_ODD (1)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tape_out   (tape_out),
        .relay      (relay),
        .rewind     (rewind),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte_count (byte_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .full       (full),
        .active     (active)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Buffer model: pending writes encoded as addr*256 + data.
    int exp_q[$];
    int exp_addr = 0;
    int exp_count = 0;
    bit exp_full = 0, exp_perr = 0, exp_ferr = 0;
    int one_lo = 42, one_hi = 42, zero_lo = 62, zero_hi = 62;

    task automatic model_clear();
        exp_addr = 0; exp_count = 0;
        exp_full = 0; exp_perr = 0; exp_ferr = 0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit bad);
        if (bad) exp_perr = 1;
        if (!exp_full) begin
            exp_q.push_back(exp_addr * 256 + int'(d));
            exp_count++;
            if (exp_addr == LAST_ADDR) exp_full = 1;
            else exp_addr++;
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * TICK_DIV) @(negedge clk_sys);
    endtask

    // One tape cycle: rising edge, high half, low half.
    task automatic cyc(input int us);
        tape_out = 1'b1;
        wait_us(us / 2);
        tape_out = 1'b0;
        wait_us(us - us / 2);
    endtask

    task automatic send_bit(input bit b);
        if (b) cyc(int'($urandom_range(one_hi, one_lo)));
        else   cyc(int'($urandom_range(zero_hi, zero_lo)));
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad);
        bit p;
        p = (~^d) ^ bad;
        model_byte(d, bad);
        send_bit(1); send_bit(1);
        send_bit(0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1);
        send_bit(1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr"},  32'(wr_addr),    32'(exp_addr));
        check({tag, "_count"}, 32'(byte_count), 32'(exp_count));
        check({tag, "_perr"},  32'(parity_err), 32'(exp_perr));
        check({tag, "_ferr"},  32'(frame_err),  32'(exp_ferr));
        check({tag, "_full"},  32'(full),       32'(exp_full));
        check({tag, "_pend"},  32'(exp_q.size()), 32'd0);
    endtask

    logic prev_wr = 1'b0;
    always @(negedge clk_sys) begin
        int e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", 32'(wr_data), 32'(e % 256));
                check("wr_addr", 32'(wr_addr), 32'(e / 256));
            end
            if (prev_wr) check("wr_pulse", 32'(prev_wr), 32'd0);
        end
        prev_wr = wr_en;
    end

    initial begin
        logic [7:0] junk;
        repeat (4) @(negedge clk_sys);
        check("rst_wr_en",  32'(wr_en), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check_state("rst");
        reset_n = 1'b1;
        relay   = 1'b1;
        wait_us(5);

        // Single clean byte at nominal cycle lengths.
        send_byte(8'h16, 1'b0);
        check("t1_active", 32'(active), 32'd1);
        check_state("t1");

        // Random cycle lengths from here on, kept clear of the thresholds.
        one_lo = 36; one_hi = 48; zero_lo = 58; zero_hi = 84;
        send_byte(8'h24, 1'b0);
        send_byte(8'h41, 1'b1);
        check_state("t2");

        // Relay drop after four data bits, then a full frame.
        junk = 8'hA3;
        send_bit(1); send_bit(1); send_bit(0);
        for (int i = 0; i < 4; i++) send_bit(junk[i]);
        relay = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        check("t3_relay_active", 32'(active), 32'd0);
        check_state("t3_low");
        relay = 1'b1;
        send_byte(8'h55, 1'b0);
        check_state("t3");

        // Glitch inside data bits aborts the byte; the next one still decodes.
        send_bit(1); send_bit(1); send_bit(0);
        send_bit(1); send_bit(0);
        cyc(10);
        exp_ferr = 1;
        send_byte(8'h3C, 1'b0);
        check_state("t4");

        // Fill the 16-entry buffer with random bytes; the 17th is dropped.
        rewind = 1'b1;
        @(negedge clk_sys);
        rewind = 1'b0;
        model_clear();
        @(negedge clk_sys);
        check_state("t5_rew0");
        for (int n = 0; n < 17; n++)
            send_byte(8'($urandom), ($urandom_range(7, 0) == 0));
        check_state("t5_full");
        rewind = 1'b1;
        @(negedge clk_sys);
        rewind = 1'b0;
        model_clear();
        @(negedge clk_sys);
        check_state("t5_rew1");

        // Silence gap mid-byte: no write, back to hunting.
        send_bit(1); send_bit(1); send_bit(0);
        send_bit(1); send_bit(0); send_bit(1);
        check("t6_active_pre", 32'(active), 32'd1);
        wait_us(120);
        check("t6_active_gap", 32'(active), 32'd0);
        check_state("t6_gap");
        send_byte(8'h7E, 1'b0);
        check_state("t6");

        // Reset mid-byte: everything returns to zero, no write.
        send_bit(1); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(1);
        reset_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk_sys);
        check("t7_wr_en",   32'(wr_en), 32'd0);
        check("t7_wr_data", 32'(wr_data), 32'd0);
        check("t7_active",  32'(active), 32'd0);
        check_state("t7_rst");
        reset_n = 1'b1;
        wait_us(5);
        send_byte(8'h99, 1'b0);
        check_state("t7");

        wait_us(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
